cvxif_result_buffer: RTL and testbench
======================================

# cvxif_result_buffer

Ordered result buffer between the example coprocessor's CV-X-IF result port and the CPU's result interface. The coprocessor asserts result valid without honouring result ready, so this block captures every result into a circular queue. It presents the results to the core with a proper valid/ready handshake and discards queued results whose instruction is killed on the commit interface. It also reports overflow when the coprocessor produces a result while the queue is full.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- ID_WIDTH, 3, instruction id width (matches X_ID_WIDTH)
- DATA_WIDTH, 32, result data width (matches X_DATAWIDTH)
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  coprocessor result valid; no backpressure exists upstream
- in_id_i  in  ID_WIDTH  result instruction id
- in_data_i  in  DATA_WIDTH  result data
- in_rd_i  in  5  destination register
- in_we_i  in  1  writeback enable
- in_exc_i  in  1  exception flag
- in_exccode_i  in  6  exception code
- commit_valid_i  in  1  commit interface valid
- commit_id_i  in  ID_WIDTH  committed or killed id
- commit_kill_i  in  1  kill qualifier for commit_id_i
- out_valid_o  out  1  head result valid to core
- out_ready_i  in  1  core accepts result
- out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o, out_exccode_o  out  as inputs  head entry fields
- full_o  out  1  allocated slots == DEPTH
- empty_o  out  1  allocated slots == 0
- usage_o  out  $clog2(DEPTH)+1  allocated slot count, 0..DEPTH
- overflow_o  out  1  sticky; set when a result is dropped
- drop_cnt_o  out  8  saturating count of dropped results
- clr_err_i  in  1  clears overflow_o and drop_cnt_o

## Operation
- Storage: DEPTH slots plus a live bit per slot, write pointer, read pointer and a count register. Pointers wrap modulo DEPTH.
- Push:
  - Occurs when in_valid_i is high and (!full_o or pop_this_cycle).
  - Writes all fields at the write pointer with live=1 and increments the write pointer.
- Pop:
  - pop_this_cycle = !empty_o and (!head_live or (out_valid_o and out_ready_i)).
  - A dead head is therefore discarded silently, one per cycle, and is never presented to the core.
- out_valid_o = !empty_o and head_live. The out_* fields drive the head slot contents directly from registers.
- out_we_o = head_we and out_valid_o.
- Kill:
  - When commit_valid_i and commit_kill_i are both high, every allocated slot whose id equals commit_id_i has its live bit cleared.
  - A result pushed in the same cycle with a matching id is written with live=0.
- Kill versus handshake on the head in the same cycle: the handshake wins, because the transfer has already happened. The pop completes normally.
- Commit without kill: no effect on the buffer.
- Overflow:
  - Triggered by in_valid_i while full_o with no pop in that cycle. The result is dropped.
  - overflow_o is set to 1 and drop_cnt_o increments, saturating at 255.
  - If clr_err_i coincides with a drop, the drop wins: overflow_o=1 and drop_cnt_o=1.
- Count update: count += push - pop. Simultaneous push and pop leaves usage_o unchanged.

## Timing
- Reset values:
  - out_valid_o=0 and all out_* fields 0.
  - empty_o=1, full_o=0, usage_o=0.
  - overflow_o=0, drop_cnt_o=0.
  - Pointers 0, all live bits 0.
- Reset mid-operation discards all queued results; the next cycle behaves as after reset.
- Latency: a result pushed in cycle N appears on out_valid_o in cycle N+1 at the earliest. There is no fall-through.
- Throughput: one push and one pop per cycle.
- Kill latency: a kill in cycle N removes matching entries from out_valid_o starting in cycle N+1.
- Each dead head costs one bubble cycle.
- Status outputs are registered-state derived and update the cycle after the causing event.
- Ordering: results leave in arrival order, with killed entries removed.

## Test plan
- Single pass: after reset, push id=2, data=0x1234, rd=5, we=1 with out_ready_i=1. Required: out_valid_o=1 the next cycle with the same fields, then empty_o=1 the cycle after.
- Backpressure and full: with DEPTH=4 and out_ready_i=0, push ids 0,1,2,3. Required: full_o=1 and usage_o=4. Then raise out_ready_i. Required: ids 0,1,2,3 exit in order over 4 consecutive cycles.
- Overflow: with the buffer full and out_ready_i=0, push id=4 twice. Required: overflow_o=1, drop_cnt_o=2, queue contents unchanged. Then pulse clr_err_i. Required: overflow_o=0, drop_cnt_o=0.
- Kill: queue ids 1,2,3 with out_ready_i=0, then apply commit_valid_i=1, kill=1, id=2. Required: with out_ready_i=1, the outputs are id 1 and then id 3; id 2 never appears and usage_o reaches 0.
- Same-cycle cases:
  - A kill of id 5 coincident with the push of id 5. Required: id 5 is never output.
  - A kill of the head id coincident with out_ready_i=1. Required: the head is delivered exactly once.
  - Push while full with a simultaneous pop. Required: the push is accepted and no overflow is flagged.
- Reset mid-operation: with 3 entries queued and overflow_o=1, assert rst_i for one cycle. Required: all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/cvxif_result_buffer.sv
// Ordered result queue between the coprocessor's CV-X-IF result port (no backpressure)
// and the core: captures every result, drops killed entries, flags overflow.
module cvxif_result_buffer #(
    parameter int DEPTH      = 4,
    parameter int ID_WIDTH   = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    input  logic [ID_WIDTH-1:0]   in_id_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [4:0]            in_rd_i,
    input  logic                  in_we_i,
    input  logic                  in_exc_i,
    input  logic [5:0]            in_exccode_i,
    input  logic                  commit_valid_i,
    input  logic [ID_WIDTH-1:0]   commit_id_i,
    input  logic                  commit_kill_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ID_WIDTH-1:0]   out_id_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [4:0]            out_rd_o,
    output logic                  out_we_o,
    output logic                  out_exc_o,
    output logic [5:0]            out_exccode_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [$clog2(DEPTH):0] usage_o,
    output logic                  overflow_o,
    output logic [7:0]            drop_cnt_o,
    input  logic                  clr_err_i
);

    localparam int AW = $clog2(DEPTH);

    logic [ID_WIDTH-1:0]   id_q      [DEPTH];
    logic [DATA_WIDTH-1:0] data_q    [DEPTH];
    logic [4:0]            rd_q      [DEPTH];
    logic                  we_q      [DEPTH];
    logic                  exc_q     [DEPTH];
    logic [5:0]            exccode_q [DEPTH];
    logic [DEPTH-1:0]      live_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  overflow_q;
    logic [7:0]            drop_cnt_q;

    logic             head_live, push, pop, drop, kill_en, push_killed;
    logic [DEPTH-1:0] alloc;

    // Output handshake: a result transfers on a cycle where out_valid_o and
    // out_ready_i are both high; out_valid_o never depends on out_ready_i.
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign usage_o     = count_q;
    assign head_live   = live_q[rd_ptr_q];
    assign out_valid_o = !empty_o && head_live;
    assign pop         = !empty_o && (!head_live || (out_valid_o && out_ready_i));
    assign push        = in_valid_i && (!full_o || pop);
    assign drop        = in_valid_i && full_o && !pop;
    assign kill_en     = commit_valid_i && commit_kill_i;
    assign push_killed = kill_en && (commit_id_i == in_id_i);

    assign out_id_o      = id_q[rd_ptr_q];
    assign out_data_o    = data_q[rd_ptr_q];
    assign out_rd_o      = rd_q[rd_ptr_q];
    assign out_we_o      = we_q[rd_ptr_q] && out_valid_o;
    assign out_exc_o     = exc_q[rd_ptr_q];
    assign out_exccode_o = exccode_q[rd_ptr_q];
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

    // A slot is allocated when its distance from the read pointer is below the count.
    always_comb begin
        alloc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc[i] = ({1'b0, AW'(i) - rd_ptr_q} < count_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            live_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]      <= '0;
                data_q[i]    <= '0;
                rd_q[i]      <= '0;
                we_q[i]      <= 1'b0;
                exc_q[i]     <= 1'b0;
                exccode_q[i] <= '0;
            end
        end else begin
            if (kill_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (alloc[i] && (id_q[i] == commit_id_i)) live_q[i] <= 1'b0;
                end
            end
            // The push write comes last so a slot reused on a full push+pop takes fresh state.
            if (push) begin
                id_q[wr_ptr_q]      <= in_id_i;
                data_q[wr_ptr_q]    <= in_data_i;
                rd_q[wr_ptr_q]      <= in_rd_i;
                we_q[wr_ptr_q]      <= in_we_i;
                exc_q[wr_ptr_q]     <= in_exc_i;
                exccode_q[wr_ptr_q] <= in_exccode_i;
                live_q[wr_ptr_q]    <= !push_killed;
                wr_ptr_q            <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (pop && !push) count_q <= count_q - (AW+1)'(1);

            if (drop) begin
                overflow_q <= 1'b1;
                if (clr_err_i)                drop_cnt_q <= 8'd1;
                else if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end else if (clr_err_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed bench for cvxif_result_buffer: each task drives one scenario and checks inline;
// delivered results are matched against an expected queue of {id, data}.
module tb_cvxif_result_buffer;

    localparam int IDW = 3;
    localparam int DW  = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [IDW-1:0] in_id_i = '0;
    logic [DW-1:0] in_data_i = '0;
    logic [4:0]    in_rd_i = '0;
    logic          in_we_i = 1'b0;
    logic          in_exc_i = 1'b0;
    logic [5:0]    in_exccode_i = '0;
    logic          commit_valid_i = 1'b0;
    logic [IDW-1:0] commit_id_i = '0;
    logic          commit_kill_i = 1'b0;
    logic          out_ready_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic          out_valid_o, out_we_o, out_exc_o, full_o, empty_o, overflow_o;
    logic [IDW-1:0] out_id_o;
    logic [DW-1:0] out_data_o;
    logic [4:0]    out_rd_o;
    logic [5:0]    out_exccode_o;
    logic [2:0]    usage_o;
    logic [7:0]    drop_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IDW+DW-1:0] exp_q[$];

    cvxif_result_buffer #(.DEPTH(4), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_id_i(in_id_i), .in_data_i(in_data_i), .in_rd_i(in_rd_i),
        .in_we_i(in_we_i), .in_exc_i(in_exc_i), .in_exccode_i(in_exccode_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_id_o(out_id_o),
        .out_data_o(out_data_o), .out_rd_o(out_rd_o), .out_we_o(out_we_o), .out_exc_o(out_exc_o),
        .out_exccode_o(out_exccode_o), .full_o(full_o), .empty_o(empty_o), .usage_o(usage_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clr_err_i(clr_err_i)
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drivers
    task automatic push(input logic [IDW-1:0] id, input logic [DW-1:0] data, input logic [4:0] rd,
                        input logic we, input logic exc, input logic [5:0] ecode);
        in_id_i = id; in_data_i = data; in_rd_i = rd;
        in_we_i = we; in_exc_i = exc; in_exccode_i = ecode;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic sb_add(input logic [IDW-1:0] id, input logic [DW-1:0] data);
        exp_q.push_back({id, data});
    endtask

    task automatic fill4(input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) begin
            push(IDW'(i), base + DW'(i), 5'(i + 1), 1'b1, 1'b0, 6'(i));
            sb_add(IDW'(i), base + DW'(i));
        end
    endtask

    // Scoreboard: drain with out_ready_i=1, every delivered result must match the queue head.
    task automatic drain(input string name, input int budget, output int cycles);
        logic [IDW+DW-1:0] exp;
        cycles = 0;
        out_ready_i = 1'b1;
        while (!empty_o && cycles < budget) begin
            if (out_valid_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_order: got id %0d data %h, required no result", name, out_id_o, out_data_o);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_id_o, out_data_o} !== exp) begin
                        n_fail++;
                        $display("FAIL %s_order: got id %0d data %h, required id %0d data %h",
                                 name, out_id_o, out_data_o, exp[IDW+DW-1:DW], exp[DW-1:0]);
                    end
                end
            end
            tick();
            cycles++;
        end
        out_ready_i = 1'b0;
        n_checks++;
        if (empty_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_empty: got empty_o %0b after %0d cycles, required 1", name, empty_o, cycles);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing: got %0d results undelivered, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_values(input string name);
        n_checks++;
        if ({out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o, out_exccode_o} !== '0) begin
            n_fail++;
            $display("FAIL %s_out: got valid %0b id %0d data %h rd %0d we %0b exc %0b code %0d, required all 0",
                     name, out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o, out_exccode_o);
        end
        n_checks++;
        if ({empty_o, full_o, usage_o, overflow_o, drop_cnt_o} !== {1'b1, 1'b0, 3'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL %s_status: got empty %0b full %0b usage %0d ovf %0b drops %0d, required 1 0 0 0 0",
                     name, empty_o, full_o, usage_o, overflow_o, drop_cnt_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check_reset_values("reset");
    endtask

    task automatic test_single_pass();
        out_ready_i = 1'b1;
        push(3'd2, 32'h1234, 5'd5, 1'b1, 1'b0, 6'd0);
        n_checks++;
        if ({out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o} !==
            {1'b1, 3'd2, 32'h1234, 5'd5, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL single_fields: got valid %0b id %0d data %h rd %0d we %0b exc %0b, required 1 2 1234 5 1 0",
                     out_valid_o, out_id_o, out_data_o, out_rd_o, out_we_o, out_exc_o);
        end
        tick();
        out_ready_i = 1'b0;
        n_checks++;
        if ({empty_o, out_valid_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_empty: got empty %0b valid %0b, required 1 0", empty_o, out_valid_o);
        end
    endtask

    task automatic test_backpressure_full();
        int cyc;
        fill4(32'h100);
        n_checks++;
        if ({full_o, usage_o, out_exccode_o, out_rd_o} !== {1'b1, 3'd4, 6'd0, 5'd1}) begin
            n_fail++;
            $display("FAIL full_status: got full %0b usage %0d code %0d rd %0d, required 1 4 0 1",
                     full_o, usage_o, out_exccode_o, out_rd_o);
        end
        drain("full", 20, cyc);
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL full_cycles: got %0d drain cycles, required 4", cyc);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        fill4(32'h200);
        push(3'd4, 32'hDEAD, 5'd9, 1'b1, 1'b0, 6'd0);
        push(3'd4, 32'hBEEF, 5'd9, 1'b1, 1'b0, 6'd0);
        n_checks++;
        if ({overflow_o, drop_cnt_o, usage_o, out_id_o, out_data_o} !== {1'b1, 8'd2, 3'd4, 3'd0, 32'h200}) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf %0b drops %0d usage %0d head id %0d data %h, required 1 2 4 0 200",
                     overflow_o, drop_cnt_o, usage_o, out_id_o, out_data_o);
        end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        n_checks++;
        if ({overflow_o, drop_cnt_o} !== {1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL overflow_clear: got ovf %0b drops %0d, required 0 0", overflow_o, drop_cnt_o);
        end
        clr_err_i = 1'b1;
        push(3'd4, 32'hF00D, 5'd9, 1'b1, 1'b0, 6'd0);
        clr_err_i = 1'b0;
        n_checks++;
        if ({overflow_o, drop_cnt_o} !== {1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL overflow_clr_vs_drop: got ovf %0b drops %0d, required 1 1", overflow_o, drop_cnt_o);
        end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        drain("overflow", 20, cyc);
    endtask

    task automatic test_kill();
        int cyc;
        out_ready_i = 1'b0;
        push(3'd1, 32'h301, 5'd1, 1'b1, 1'b0, 6'd0); sb_add(3'd1, 32'h301);
        push(3'd2, 32'h302, 5'd2, 1'b1, 1'b0, 6'd0);
        push(3'd3, 32'h303, 5'd3, 1'b1, 1'b0, 6'd0); sb_add(3'd3, 32'h303);
        // A plain commit of id 1 must not disturb anything.
        commit_valid_i = 1'b1; commit_id_i = 3'd1; commit_kill_i = 1'b0;
        tick();
        commit_id_i = 3'd2; commit_kill_i = 1'b1;
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        n_checks++;
        if ({usage_o, out_valid_o, out_id_o} !== {3'd3, 1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL kill_pre: got usage %0d valid %0b id %0d, required 3 1 1", usage_o, out_valid_o, out_id_o);
        end
        drain("kill", 20, cyc);
        n_checks++;
        if (cyc != 3) begin
            n_fail++;
            $display("FAIL kill_bubble: got %0d drain cycles, required 3", cyc);
        end
    endtask

    task automatic test_same_cycle();
        int cyc;
        // Kill coincident with the push of the same id.
        push(3'd6, 32'h406, 5'd6, 1'b1, 1'b0, 6'd0); sb_add(3'd6, 32'h406);
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 3'd5;
        push(3'd5, 32'h405, 5'd5, 1'b1, 1'b0, 6'd0);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        push(3'd7, 32'h407, 5'd7, 1'b1, 1'b1, 6'h2A); sb_add(3'd7, 32'h407);
        n_checks++;
        if (usage_o !== 3'd3) begin
            n_fail++;
            $display("FAIL samekill_usage: got %0d, required 3", usage_o);
        end
        drain("samekill", 20, cyc);

        // Kill of the head id in the cycle it is handed over.
        push(3'd1, 32'h501, 5'd1, 1'b1, 1'b0, 6'd0);
        out_ready_i = 1'b1;
        commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 3'd1;
        n_checks++;
        if ({out_valid_o, out_id_o, out_data_o} !== {1'b1, 3'd1, 32'h501}) begin
            n_fail++;
            $display("FAIL headkill_deliver: got valid %0b id %0d data %h, required 1 1 501",
                     out_valid_o, out_id_o, out_data_o);
        end
        tick();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        n_checks++;
        if ({out_valid_o, empty_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL headkill_once: got valid %0b empty %0b, required 0 1", out_valid_o, empty_o);
        end
        out_ready_i = 1'b0;

        // Push while full with a simultaneous pop.
        fill4(32'h600);
        out_ready_i = 1'b1;
        n_checks++;
        if ({out_valid_o, out_id_o} !== {1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL fullpop_head: got valid %0b id %0d, required 1 0", out_valid_o, out_id_o);
        end
        void'(exp_q.pop_front());
        push(3'd4, 32'h604, 5'd4, 1'b0, 1'b0, 6'd0); sb_add(3'd4, 32'h604);
        out_ready_i = 1'b0;
        n_checks++;
        if ({overflow_o, drop_cnt_o, usage_o, full_o} !== {1'b0, 8'd0, 3'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL fullpop_accept: got ovf %0b drops %0d usage %0d full %0b, required 0 0 4 1",
                     overflow_o, drop_cnt_o, usage_o, full_o);
        end
        drain("fullpop", 20, cyc);
    endtask

    task automatic test_saturation();
        int cyc;
        fill4(32'h700);
        in_id_i = 3'd5; in_data_i = 32'hFFFF; in_valid_i = 1'b1;
        repeat (260) tick();
        in_valid_i = 1'b0;
        n_checks++;
        if ({overflow_o, drop_cnt_o, usage_o} !== {1'b1, 8'd255, 3'd4}) begin
            n_fail++;
            $display("FAIL saturate: got ovf %0b drops %0d usage %0d, required 1 255 4",
                     overflow_o, drop_cnt_o, usage_o);
        end
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        drain("saturate", 20, cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        fill4(32'h800);
        push(3'd5, 32'h805, 5'd5, 1'b1, 1'b1, 6'h3F);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        n_checks++;
        if ({usage_o, overflow_o} !== {3'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL resetmid_pre: got usage %0d ovf %0b, required 3 1", usage_o, overflow_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
        check_reset_values("resetmid");
        push(3'd3, 32'h903, 5'd3, 1'b1, 1'b0, 6'd0); sb_add(3'd3, 32'h903);
        drain("after_reset", 20, cyc);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_backpressure_full();
        test_overflow();
        test_kill();
        test_same_cycle();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
